uart_transmitter: RTL

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_transmitter
//  Purpose  : 8N1 UART transmitter with a small transmit FIFO in front of the
//             shifter. Bytes are queued on a valid/ready handshake. They are
//             sent LSB first with one start bit and one stop bit, and each bit
//             lasts BIT_DIV = CLK_FREQ/BAUD_RATE clocks. Frames go out
//             back to back with no gap while the queue is non-empty.
//  Ports    : clk        - system clock, rising edge
//             reset      - synchronous, active-low reset
//             tx_data    - byte to queue
//             tx_valid   - tx_data is valid this cycle
//             tx_ready   - queue can accept a byte this cycle
//             TxD        - registered serial output, idle high
//             tx_busy    - frame in progress or queue non-empty
//             fifo_count - queued bytes, excluding the one being shifted
//  Revision : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9_600,
  parameter int FIFO_DEPTH = 4      // power of two, >= 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         TxD,
  output logic                         tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  // Clocks per bit; values below 2 are not supported.
  localparam int BIT_DIV = CLK_FREQ / BAUD_RATE;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int BAUD_W  = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;

  localparam logic [BAUD_W-1:0] c_BAUD_LAST = BAUD_W'(BIT_DIV - 1);
  localparam logic [CNT_W-1:0]  c_FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_next;
  logic [2:0]        r_bit_idx;
  logic [2:0]        w_bit_idx_next;
  logic [7:0]        r_shift;
  logic              r_txd;
  logic              w_txd_cur;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_has_data;
  logic              w_bit_end;

  // A full queue refuses a push even when a pop happens on the same edge.
  assign tx_ready   = (r_count < c_FIFO_FULL);
  assign w_push     = tx_valid && tx_ready;
  assign w_has_data = (r_count != '0);
  assign w_bit_end  = (r_baud == c_BAUD_LAST);

  assign TxD        = r_txd;
  assign tx_busy    = (r_state != IDLE) || w_has_data;
  assign fifo_count = r_count;

  // Next-state logic. The baud counter clears on every state or bit change
  // and is held at zero while idle, so an idle line shows no activity.
  always_comb begin
    w_state_next   = r_state;
    w_baud_next    = r_baud + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_pop          = 1'b0;
    case (r_state)
      IDLE: begin
        w_baud_next = '0;
        if (w_has_data) begin
          w_pop        = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_baud_next    = '0;
          w_bit_idx_next = 3'd0;
          w_state_next   = DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_baud_next    = '0;
          w_bit_idx_next = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) begin
            w_state_next = STOP;
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_baud_next = '0;
          // Popping on the last stop clock chains frames with no idle gap.
          if (w_has_data) begin
            w_pop        = 1'b1;
            w_state_next = START;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_baud_next  = '0;
        w_state_next = IDLE;
      end
    endcase
  end

  // Line level for the current state; registered into TxD, so the line
  // trails the state register by one clock.
  always_comb begin
    w_txd_cur = 1'b1;
    case (r_state)
      START:   w_txd_cur = 1'b0;
      DATA:    w_txd_cur = r_shift[r_bit_idx];
      default: w_txd_cur = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_txd     <= w_txd_cur;
      if (w_pop) begin
        r_shift  <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Queue storage needs no reset; pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

endmodule
`default_nettype wire
